vigenere_stream_cipher: RTL

- Clocked, streaming successor to the combinational `encrypt` block.
- Applies a Vigenère shift (mod 26, uppercase A–Z) to a byte stream, `p_message_length` bytes per beat, using a loaded `p_secret_length`-byte key.
- Supports run-time encrypt/decrypt mode and valid/ready handshakes on both sides.
- Keeps a rolling key index across beats, so arbitrary-length messages are processed.

---
 rtl/vigenere_stream_cipher.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vigenere_stream_cipher.sv
`default_nettype none
// ============================================================================
// Module   : vigenere_stream_cipher
// Purpose  : Streaming Vigenere cipher (uppercase A-Z, mod 26) with a loadable
//            key, run-time encrypt/decrypt and valid/ready on both sides.
//            Non-letter bytes pass through and do not advance the key index.
// Options  : VIGENERE_BYTE_CNT_EN adds o_r_letter_cnt, a saturating count of
//            letter bytes transformed since reset or the last key load.
// Revision : 1.0 - initial release
// ============================================================================
module vigenere_stream_cipher #(
  parameter int p_message_length = 1,
  parameter int p_secret_length  = 6,
  parameter int p_idx_w          = (p_secret_length > 1) ? $clog2(p_secret_length) : 1
) (
  input  logic                          i_w_clk,
  input  logic                          i_w_rst_n,
  input  logic [p_secret_length*8-1:0]  i_w_secret,
  input  logic                          i_w_key_load,
  input  logic                          i_w_mode,
  input  logic [p_message_length*8-1:0] i_w_text,
  input  logic                          i_w_valid,
  output logic                          o_w_ready,
  output logic [p_message_length*8-1:0] o_r_cipher,
  output logic                          o_r_valid,
  input  logic                          i_w_ready,
  output logic                          o_r_key_valid
`ifdef VIGENERE_BYTE_CNT_EN
  ,
  output logic [31:0]                   o_r_letter_cnt
`endif
);

  localparam int ML = p_message_length;
  localparam int SL = p_secret_length;
  localparam logic [p_idx_w-1:0] IDX_LAST = p_idx_w'(SL - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // True for 'A'..'Z'
  function automatic logic is_letter(input logic [7:0] b);
    return (b >= 8'h41) && (b <= 8'h5A);
  endfunction

  // Key byte to shift amount; non-letter key bytes shift by zero.
  // For letters b[4:0] runs 1..26, so subtracting one yields 0..25.
  function automatic logic [5:0] key_shift(input logic [7:0] b);
    return is_letter(b) ? ({1'b0, b[4:0]} - 6'd1) : 6'd0;
  endfunction

  // Shift one letter; 6-bit intermediates never exceed 51, so no overflow.
  function automatic logic [7:0] shift_letter(input logic [7:0] b,
                                              input logic [5:0] k,
                                              input logic       dec);
    logic [5:0] t;
    logic [5:0] s;
    t = {1'b0, b[4:0]} - 6'd1;
    s = dec ? (t + 6'd26 - k) : (t + k);
    if (s >= 6'd26) s = s - 6'd26;
    return 8'h41 + {2'b00, s};
  endfunction

  state_t                  state_q, state_d;
  logic [7:0]              key_q [SL];
  logic [7:0]              key_d [SL];
  logic [p_idx_w-1:0]      idx_q, idx_d;
  logic [p_idx_w-1:0]      idx_adv;
  logic [ML*8-1:0]         cipher_q, cipher_d;
  logic                    valid_q, valid_d;
  logic [ML*8-1:0]         lane_out;
  logic [7:0]              lane_byte;
  logic [p_idx_w-1:0]      lane_idx;
  logic                    accept;
`ifdef VIGENERE_BYTE_CNT_EN
  logic [31:0]             letters;
  logic [31:0]             cnt_q, cnt_d;
  logic [32:0]             cnt_sum;
`endif

  assign o_r_key_valid = (state_q == S_RUN);
  assign o_w_ready     = (state_q == S_RUN) && !i_w_key_load && (!valid_q || i_w_ready);
  assign accept        = i_w_valid && o_w_ready;
  assign o_r_cipher    = cipher_q;
  assign o_r_valid     = valid_q;

  // Per-lane transform with a rolling key index that only advances on letters
  always_comb begin
    lane_out  = '0;
    lane_byte = '0;
    lane_idx  = idx_q;
`ifdef VIGENERE_BYTE_CNT_EN
    letters   = '0;
`endif
    for (int j = 0; j < ML; j++) begin
      lane_byte = i_w_text[(ML-1-j)*8 +: 8];
      if (is_letter(lane_byte)) begin
        lane_out[(ML-1-j)*8 +: 8] = shift_letter(lane_byte, key_shift(key_q[lane_idx]), i_w_mode);
        lane_idx = (lane_idx == IDX_LAST) ? '0 : lane_idx + p_idx_w'(1);
`ifdef VIGENERE_BYTE_CNT_EN
        letters = letters + 32'd1;
`endif
      end else begin
        lane_out[(ML-1-j)*8 +: 8] = lane_byte;
      end
    end
    idx_adv = lane_idx;
  end

  // Next-state: key load beats any beat; the output register follows valid/ready
  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    idx_d    = idx_q;
    cipher_d = cipher_q;
    valid_d  = valid_q;
    if (i_w_key_load) begin
      state_d = S_RUN;
      idx_d   = '0;
      for (int c = 0; c < SL; c++) begin
        key_d[c] = i_w_secret[(SL-1-c)*8 +: 8];
      end
    end else if (accept) begin
      idx_d = idx_adv;
    end
    if (accept) begin
      cipher_d = lane_out;
      valid_d  = 1'b1;
    end else if (valid_q && i_w_ready) begin
      valid_d  = 1'b0;
    end
  end

  // State, key, index and output registers
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cipher_q <= '0;
      valid_q  <= 1'b0;
      for (int c = 0; c < SL; c++) begin
        key_q[c] <= 8'h00;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cipher_q <= cipher_d;
      valid_q  <= valid_d;
      for (int c = 0; c < SL; c++) begin
        key_q[c] <= key_d[c];
      end
    end
  end

`ifdef VIGENERE_BYTE_CNT_EN
  assign cnt_sum        = {1'b0, cnt_q} + {1'b0, letters};
  assign o_r_letter_cnt = cnt_q;

  // Saturating letter counter, cleared on key load
  always_comb begin
    cnt_d = cnt_q;
    if (i_w_key_load) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
  end

  // Counter register
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule
`default_nettype wire
